// File: rtl/svk_axi_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : svk_axi_wr_arb
// Brief    : Two-master AXI write arbiter: round-robin AW grant, in-order W routing
//            through a write-order FIFO, ID-tagged B return to the issuing master.
//            Optional QoS-priority AW arbitration via SVK_AXI_WR_ARB_QOS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module svk_axi_wr_arb #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int LEN_W  = 8,
   parameter int OST    = 4
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic                m0_awvalid,
   output logic                m0_awready,
   input  logic [ID_W-1:0]     m0_awid,
   input  logic [ADDR_W-1:0]   m0_awaddr,
   input  logic [LEN_W-1:0]    m0_awlen,
   input  logic [2:0]          m0_awsize,
   input  logic [1:0]          m0_awburst,
   input  logic [3:0]          m0_awqos,
   input  logic                m0_wvalid,
   output logic                m0_wready,
   input  logic [DATA_W-1:0]   m0_wdata,
   input  logic [DATA_W/8-1:0] m0_wstrb,
   input  logic                m0_wlast,
   output logic                m0_bvalid,
   input  logic                m0_bready,
   output logic [ID_W-1:0]     m0_bid,
   output logic [1:0]          m0_bresp,
   input  logic                m1_awvalid,
   output logic                m1_awready,
   input  logic [ID_W-1:0]     m1_awid,
   input  logic [ADDR_W-1:0]   m1_awaddr,
   input  logic [LEN_W-1:0]    m1_awlen,
   input  logic [2:0]          m1_awsize,
   input  logic [1:0]          m1_awburst,
   input  logic [3:0]          m1_awqos,
   input  logic                m1_wvalid,
   output logic                m1_wready,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   input  logic                m1_wlast,
   output logic                m1_bvalid,
   input  logic                m1_bready,
   output logic [ID_W-1:0]     m1_bid,
   output logic [1:0]          m1_bresp,
   output logic                s_awvalid,
   input  logic                s_awready,
   output logic [ID_W:0]       s_awid,
   output logic [ADDR_W-1:0]   s_awaddr,
   output logic [LEN_W-1:0]    s_awlen,
   output logic [2:0]          s_awsize,
   output logic [1:0]          s_awburst,
   output logic [3:0]          s_awqos,
   output logic                s_wvalid,
   input  logic                s_wready,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_wstrb,
   output logic                s_wlast,
   input  logic                s_bvalid,
   output logic                s_bready,
   input  logic [ID_W:0]       s_bid,
   input  logic [1:0]          s_bresp
);

   localparam int PTR_W = $clog2(OST);
   localparam int CNT_W = $clog2(OST) + 1;
   localparam logic [CNT_W-1:0] OST_CNT = CNT_W'(OST);

   typedef enum logic [0:0] {AW_IDLE = 1'b0, AW_HOLD = 1'b1} aw_state_t;
   typedef enum logic [0:0] {W_IDLE = 1'b0, W_BURST = 1'b1} w_state_t;

   aw_state_t         aw_state_q, aw_state_d;
   w_state_t          w_state_q, w_state_d;
   logic              rr_q, rr_d;
   logic [ID_W:0]     awid_q, awid_d;
   logic [ADDR_W-1:0] awaddr_q, awaddr_d;
   logic [LEN_W-1:0]  awlen_q, awlen_d;
   logic [2:0]        awsize_q, awsize_d;
   logic [1:0]        awburst_q, awburst_d;
   logic [3:0]        awqos_q, awqos_d;
   logic [OST-1:0]    fifo_q, fifo_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              sel, grant, push, pop, head;

   // sel is the master that would win if a grant were issued this cycle
   always_comb begin
      sel = 1'b0;
      if (m0_awvalid && m1_awvalid) begin
`ifdef SVK_AXI_WR_ARB_QOS_EN
         if (m0_awqos != m1_awqos)
            sel = (m1_awqos > m0_awqos);
         else
            sel = rr_q;
`else
         sel = rr_q;
`endif
      end else begin
         sel = m1_awvalid;
      end
   end

   always_comb begin
      aw_state_d = aw_state_q;
      rr_d       = rr_q;
      awid_d     = awid_q;
      awaddr_d   = awaddr_q;
      awlen_d    = awlen_q;
      awsize_d   = awsize_q;
      awburst_d  = awburst_q;
      awqos_d    = awqos_q;
      grant      = 1'b0;
      push       = 1'b0;
      case (aw_state_q)
         AW_IDLE: begin
            if ((m0_awvalid || m1_awvalid) && (cnt_q != OST_CNT)) begin
               grant      = 1'b1;
               rr_d       = ~sel;
               aw_state_d = AW_HOLD;
               awid_d     = sel ? {1'b1, m1_awid} : {1'b0, m0_awid};
               awaddr_d   = sel ? m1_awaddr  : m0_awaddr;
               awlen_d    = sel ? m1_awlen   : m0_awlen;
               awsize_d   = sel ? m1_awsize  : m0_awsize;
               awburst_d  = sel ? m1_awburst : m0_awburst;
               awqos_d    = sel ? m1_awqos   : m0_awqos;
            end
         end
         AW_HOLD: begin
            if (s_awready) begin
               push       = 1'b1;
               aw_state_d = AW_IDLE;
            end
         end
         default: aw_state_d = AW_IDLE;
      endcase
   end

   // awready is combinational off the grant, so it is masked while reset is held
   assign m0_awready = aresetn & grant & ~sel;
   assign m1_awready = aresetn & grant & sel;
   assign s_awvalid  = (aw_state_q == AW_HOLD);
   assign s_awid     = awid_q;
   assign s_awaddr   = awaddr_q;
   assign s_awlen    = awlen_q;
   assign s_awsize   = awsize_q;
   assign s_awburst  = awburst_q;
   assign s_awqos    = awqos_q;

   always_comb begin
      head      = fifo_q[rd_ptr_q];
      s_wdata   = head ? m1_wdata : m0_wdata;
      s_wstrb   = head ? m1_wstrb : m0_wstrb;
      s_wlast   = head ? m1_wlast : m0_wlast;
      s_wvalid  = 1'b0;
      m0_wready = 1'b0;
      m1_wready = 1'b0;
      if (w_state_q == W_BURST) begin
         s_wvalid  = head ? m1_wvalid : m0_wvalid;
         m0_wready = ~head & s_wready;
         m1_wready = head & s_wready;
      end
      pop = s_wvalid & s_wready & s_wlast;
   end

   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         fifo_d[wr_ptr_q] = awid_q[ID_W];
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop)
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d     = cnt_q + CNT_W'(push) - CNT_W'(pop);
      w_state_d = (cnt_d != '0) ? W_BURST : W_IDLE;
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         aw_state_q <= AW_IDLE;
         w_state_q  <= W_IDLE;
         rr_q       <= 1'b0;
         awid_q     <= '0;
         awaddr_q   <= '0;
         awlen_q    <= '0;
         awsize_q   <= '0;
         awburst_q  <= '0;
         awqos_q    <= '0;
         fifo_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
      end else begin
         aw_state_q <= aw_state_d;
         w_state_q  <= w_state_d;
         rr_q       <= rr_d;
         awid_q     <= awid_d;
         awaddr_q   <= awaddr_d;
         awlen_q    <= awlen_d;
         awsize_q   <= awsize_d;
         awburst_q  <= awburst_d;
         awqos_q    <= awqos_d;
         fifo_q     <= fifo_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
      end
   end

   // the extra slave-side ID bit names the master that issued the write
   assign m0_bvalid = s_bvalid & ~s_bid[ID_W];
   assign m1_bvalid = s_bvalid & s_bid[ID_W];
   assign m0_bid    = s_bid[ID_W-1:0];
   assign m1_bid    = s_bid[ID_W-1:0];
   assign m0_bresp  = s_bresp;
   assign m1_bresp  = s_bresp;
   assign s_bready  = s_bid[ID_W] ? m1_bready : m0_bready;

endmodule
`default_nettype wire

// File: tb/tb_svk_axi_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_svk_axi_wr_arb
// Brief    : Self-checking bench for svk_axi_wr_arb: directed corner sequences,
//            a B-routing vector table and randomized two-master traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_svk_axi_wr_arb;
   localparam int ID_W = 4, ADDR_W = 32, DATA_W = 64, LEN_W = 8, OST = 4;
   localparam int SW = DATA_W / 8;
   localparam int NB = 10;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   always #5 aclk = ~aclk;

   logic [1:0]        m_awvalid, m_wvalid, m_wlast, m_bready;
   logic [ID_W-1:0]   m_awid [2];
   logic [ADDR_W-1:0] m_awaddr [2];
   logic [LEN_W-1:0]  m_awlen [2];
   logic [2:0]        m_awsize [2];
   logic [1:0]        m_awburst [2];
   logic [3:0]        m_awqos [2];
   logic [DATA_W-1:0] m_wdata [2];
   logic [SW-1:0]     m_wstrb [2];
   wire  [1:0]        m_awready, m_wready, m_bvalid;
   wire  [ID_W-1:0]   m_bid [2];
   wire  [1:0]        m_bresp [2];
   logic              s_awready, s_wready, s_bvalid;
   logic [ID_W:0]     s_bid;
   logic [1:0]        s_bresp;
   wire               s_awvalid, s_wvalid, s_wlast, s_bready;
   wire  [ID_W:0]     s_awid;
   wire  [ADDR_W-1:0] s_awaddr;
   wire  [LEN_W-1:0]  s_awlen;
   wire  [2:0]        s_awsize;
   wire  [1:0]        s_awburst;
   wire  [3:0]        s_awqos;
   wire  [DATA_W-1:0] s_wdata;
   wire  [SW-1:0]     s_wstrb;

   svk_axi_wr_arb #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .OST(OST)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]), .m0_awid(m_awid[0]),
      .m0_awaddr(m_awaddr[0]), .m0_awlen(m_awlen[0]), .m0_awsize(m_awsize[0]),
      .m0_awburst(m_awburst[0]), .m0_awqos(m_awqos[0]),
      .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]), .m0_wdata(m_wdata[0]),
      .m0_wstrb(m_wstrb[0]), .m0_wlast(m_wlast[0]),
      .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]), .m0_bid(m_bid[0]), .m0_bresp(m_bresp[0]),
      .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]), .m1_awid(m_awid[1]),
      .m1_awaddr(m_awaddr[1]), .m1_awlen(m_awlen[1]), .m1_awsize(m_awsize[1]),
      .m1_awburst(m_awburst[1]), .m1_awqos(m_awqos[1]),
      .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]), .m1_wdata(m_wdata[1]),
      .m1_wstrb(m_wstrb[1]), .m1_wlast(m_wlast[1]),
      .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1]), .m1_bid(m_bid[1]), .m1_bresp(m_bresp[1]),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
      .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awqos(s_awqos),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_wlast(s_wlast),
      .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0;
      for (int i = 0; i < 2; i++) begin
         m_awid[i] = '0; m_awaddr[i] = '0; m_awlen[i] = '0; m_awsize[i] = '0;
         m_awburst[i] = '0; m_awqos[i] = '0; m_wdata[i] = '0; m_wstrb[i] = '0;
      end
      s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bid = '0; s_bresp = '0;
   endtask

   task automatic pulse_reset();
      aresetn = 1'b0;
      @(posedge aclk); #1;
      aresetn = 1'b1;
   endtask

   // Reset values, then both masters requesting single-beat writes from reset
   task automatic t_reset_and_rr();
      int got[$];
      int extra = 0;
      idle_inputs();
      m_awvalid = 2'b11; m_awid[0] = 4'h1; m_awid[1] = 4'h2;
      s_awready = 1'b1; s_wready = 1'b1;
      aresetn = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      check("reset_outputs", {m_awready, s_awvalid, s_wvalid, m_wready, s_awid, s_awaddr},
            {2'b00, 1'b0, 1'b0, 2'b00, 5'h00, 32'h0});
      aresetn = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge aclk);
         if (got.size() == 4 && m_awready != 2'b00) extra++;
         if (s_awvalid && s_awready) got.push_back(int'(s_awid[ID_W]));
      end
      check("rr_count", got.size(), 4);
      for (int i = 0; i < 4; i++)
         check($sformatf("rr_grant%0d", i), (i < got.size()) ? got[i] : -1, i % 2);
      check("fifo_full_no_grant", extra, 0);
   endtask

   // s_awready held low in AW_HOLD: payload must stay frozen, no new awready
   task automatic t_hold_stable();
      idle_inputs();
      m_awvalid = 2'b01; m_awid[0] = 4'h5; m_awaddr[0] = 32'h1234; m_awlen[0] = 8'd2;
      pulse_reset();
      for (int c = 0; c < 10; c++) begin
         @(negedge aclk);
         if (s_awvalid) break;
      end
      @(posedge aclk); #1;
      m_awaddr[0] = 32'hDEAD; m_awid[0] = 4'hA; m_awvalid = 2'b11; m_awid[1] = 4'h6;
      for (int c = 0; c < 5; c++) begin
         @(negedge aclk);
         check("hold_stable", {s_awvalid, s_awid, s_awaddr, s_awlen, m_awready},
               {1'b1, 5'h05, 32'h1234, 8'd2, 2'b00});
      end
      @(posedge aclk); #1;
      s_awready = 1'b1;
      @(negedge aclk);
      check("hold_release", s_awvalid, 1'b1);
      @(negedge aclk);
      check("rr_after_m0", m_awready, 2'b10);
   endtask

   // FIFO depth limit, registered-count refill, then reset in the middle of it
   task automatic t_ost_and_reset();
      int n = 0;
      idle_inputs();
      m_awvalid = 2'b01; m_awid[0] = 4'h7; m_awaddr[0] = 32'hCAFE_0000;
      m_wvalid = 2'b01; m_wlast = 2'b01; s_awready = 1'b1;
      pulse_reset();
      for (int c = 0; c < 20; c++) begin
         @(negedge aclk);
         if (m_awready[0]) n++;
      end
      check("ost_accept", n, OST);
      check("ost_wvalid", s_wvalid, 1'b1);
      @(posedge aclk); #1;
      s_wready = 1'b1;
      @(negedge aclk);
      check("ost_pop_cycle", {m_wready, m_awready}, {2'b01, 2'b00});
      @(posedge aclk); #1;
      s_wready = 1'b0;
      n = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge aclk);
         if (m_awready[0]) n++;
      end
      check("ost_refill", n, 1);
      s_wready = 1'b1;
      aresetn = 1'b0;
      @(posedge aclk); #1;
      check("rst_mid_burst", {s_awvalid, s_wvalid, m_awready, m_wready, s_awid, s_awaddr},
            {1'b0, 1'b0, 2'b00, 2'b00, 5'h00, 32'h0});
      aresetn = 1'b1;
   endtask

   // m1 presents W before its AW reaches the head; m0's 4-beat burst goes first
   task automatic t_w_order();
      logic [1:0] hs_aw, hs_w;
      logic [7:0] seq[$];
      logic [7:0] exp_seq[6];
      int b0 = 0, b1 = 0;
      bit m1_acc = 0, early = 0;
      exp_seq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1};
      idle_inputs();
      s_awready = 1'b1; s_wready = 1'b1;
      m_awvalid = 2'b01; m_awlen[0] = 8'd3; m_awlen[1] = 8'd1;
      m_awid[0] = 4'h1; m_awid[1] = 4'h2;
      m_wvalid = 2'b10; m_wdata[1] = 64'hB0;
      pulse_reset();
      for (int c = 0; c < 40 && seq.size() < 6; c++) begin
         @(negedge aclk);
         hs_aw = m_awvalid & m_awready;
         hs_w  = m_wvalid & m_wready;
         if (m_wready[1] && b0 < 4) early = 1;
         if (s_wvalid && s_wready) seq.push_back(s_wdata[7:0]);
         @(posedge aclk); #1;
         if (hs_aw[0]) begin m_awvalid[0] = 1'b0; m_awvalid[1] = 1'b1; end
         if (hs_aw[1]) begin m_awvalid[1] = 1'b0; m1_acc = 1; end
         if (hs_w[0]) b0++;
         if (hs_w[1]) b1++;
         m_wvalid[0] = m1_acc && (b0 < 4);
         m_wdata[0]  = 64'(8'hA0 + b0);
         m_wlast[0]  = (b0 == 3);
         m_wvalid[1] = (b1 < 2);
         m_wdata[1]  = 64'(8'hB0 + b1);
         m_wlast[1]  = (b1 == 1);
      end
      check("w_m1_stalled", early, 1'b0);
      check("w_beats", seq.size(), 6);
      for (int i = 0; i < 6; i++)
         check($sformatf("w_order%0d", i), (i < seq.size()) ? seq[i] : 8'hxx, exp_seq[i]);
   endtask

   task automatic t_qos();
      logic [1:0] exp_first;
`ifdef SVK_AXI_WR_ARB_QOS_EN
      exp_first = 2'b10;
`else
      exp_first = 2'b01;
`endif
      idle_inputs();
      m_awvalid = 2'b11; m_awqos[0] = 4'd2; m_awqos[1] = 4'd9; s_awready = 1'b1;
      pulse_reset();
      @(negedge aclk);
      check("qos_first", m_awready, exp_first);
      @(negedge aclk);
      @(negedge aclk);
      check("qos_second", m_awready, 2'b10);
      idle_inputs();
      m_awvalid = 2'b11; m_awqos[0] = 4'd5; m_awqos[1] = 4'd5; s_awready = 1'b1;
      pulse_reset();
      @(negedge aclk);
      check("qos_tie_rr", m_awready, 2'b01);
   endtask

   typedef struct packed {
      logic            bvalid;
      logic [ID_W:0]   bid;
      logic [1:0]      bresp;
      logic [1:0]      bready;
      logic [1:0]      exp_bvalid;
      logic [ID_W-1:0] exp_bid;
      logic [1:0]      exp_bresp;
      logic            exp_bready;
   } bvec_t;

   task automatic t_b_table();
      bvec_t bv[6];
      bv[0] = '{1'b1, 5'h13, 2'd2, 2'b10, 2'b10, 4'h3, 2'd2, 1'b1};
      bv[1] = '{1'b1, 5'h13, 2'd2, 2'b01, 2'b10, 4'h3, 2'd2, 1'b0};
      bv[2] = '{1'b1, 5'h0A, 2'd1, 2'b01, 2'b01, 4'hA, 2'd1, 1'b1};
      bv[3] = '{1'b0, 5'h1F, 2'd3, 2'b11, 2'b00, 4'hF, 2'd3, 1'b1};
      bv[4] = '{1'b1, 5'h00, 2'd0, 2'b10, 2'b01, 4'h0, 2'd0, 1'b0};
      bv[5] = '{1'b1, 5'h1C, 2'd3, 2'b00, 2'b10, 4'hC, 2'd3, 1'b0};
      for (int i = 0; i < 6; i++) begin
         s_bvalid = bv[i].bvalid; s_bid = bv[i].bid; s_bresp = bv[i].bresp;
         m_bready = bv[i].bready;
         #1;
         check($sformatf("b_route%0d", i),
               {m_bvalid, m_bid[1], m_bid[0], m_bresp[1], m_bresp[0], s_bready},
               {bv[i].exp_bvalid, bv[i].exp_bid, bv[i].exp_bid, bv[i].exp_bresp,
                bv[i].exp_bresp, bv[i].exp_bready});
      end
      s_bvalid = 1'b0; m_bready = '0;
   endtask

   function automatic logic [LEN_W-1:0] f_len(int m, int j);
      return LEN_W'((m * 5 + j * 3) % 4);
   endfunction
   function automatic logic [ADDR_W-1:0] f_addr(int m, int j);
      return ADDR_W'(32'h1000 * (m + 1) + j * 64);
   endfunction
   function automatic logic [ID_W-1:0] f_id(int m, int j);
      return ID_W'(j + 3 * m);
   endfunction
   function automatic logic [DATA_W-1:0] f_data(int m, int j, int b);
      return {32'(m), 16'(j), 16'(b)} ^ 64'h5A5A_C3C3_0F0F_9696;
   endfunction
   function automatic logic [SW-1:0] f_strb(int m, int j, int b);
      return SW'(j * 17 + b * 3 + m);
   endfunction

   typedef struct {
      int m;
      int j;
      int len;
   } ord_t;

   // Random traffic: every slave-side AW/W must follow the masters' own sequences,
   // W bursts must follow slave-side AW order, ties alternate between masters.
   task automatic t_random();
      ord_t ordq[$];
      int aw_n[2] = '{0, 0};
      int w_j[2] = '{0, 0};
      int w_b[2] = '{0, 0};
      int aw_seen[2] = '{0, 0};
      int last_g = 1;
      int beat = 0;
      bit done = 0;
      logic [1:0] hs_aw, hs_w, exp_g;
      idle_inputs();
      pulse_reset();
      for (int c = 0; c < 3000 && !done; c++) begin
         @(negedge aclk);
         hs_aw = m_awvalid & m_awready;
         hs_w  = m_wvalid & m_wready;
         if (m_awready != 2'b00) begin
            exp_g = (m_awvalid == 2'b11) ? ((last_g == 1) ? 2'b01 : 2'b10) : m_awvalid;
            check("rnd_grant", m_awready, exp_g);
            last_g = m_awready[1] ? 1 : 0;
         end
         if (s_awvalid && s_awready) begin
            int m, j;
            m = int'(s_awid[ID_W]);
            j = aw_seen[m];
            check("rnd_aw_fwd", {s_awid, s_awaddr, s_awlen, s_awsize},
                  {m[0], f_id(m, j), f_addr(m, j), f_len(m, j), (m == 1) ? 3'd2 : 3'd3});
            check("rnd_fifo_bound", ordq.size() < OST, 1'b1);
            ordq.push_back('{m, j, int'(f_len(m, j))});
            aw_seen[m]++;
         end
         if (m_wready != 2'b00) begin
            int hm;
            hm = (ordq.size() > 0) ? ordq[0].m : 0;
            check("rnd_w_head", {ordq.size() > 0, m_wready}, {1'b1, (hm == 1) ? 2'b10 : 2'b01});
         end
         if (ordq.size() == 0) check("rnd_w_idle", s_wvalid, 1'b0);
         if (s_wvalid && s_wready) begin
            if (ordq.size() == 0) begin
               check("rnd_w_unexpected", 1'b1, 1'b0);
            end else begin
               check("rnd_w_beat", {s_wdata, s_wstrb, s_wlast},
                     {f_data(ordq[0].m, ordq[0].j, beat), f_strb(ordq[0].m, ordq[0].j, beat),
                      beat == ordq[0].len});
               if (beat == ordq[0].len) begin
                  void'(ordq.pop_front());
                  beat = 0;
               end else begin
                  beat++;
               end
            end
         end
         @(posedge aclk); #1;
         for (int m = 0; m < 2; m++) begin
            if (hs_aw[m]) aw_n[m]++;
            if (hs_w[m]) begin
               if (w_b[m] == int'(f_len(m, w_j[m]))) begin w_j[m]++; w_b[m] = 0; end
               else w_b[m]++;
            end
            if (!(m_awvalid[m] && !hs_aw[m]))
               m_awvalid[m] = (aw_n[m] < NB) && ($urandom_range(0, 3) != 0);
            m_awid[m] = f_id(m, aw_n[m]); m_awaddr[m] = f_addr(m, aw_n[m]);
            m_awlen[m] = f_len(m, aw_n[m]); m_awsize[m] = (m == 1) ? 3'd2 : 3'd3;
            m_awburst[m] = 2'b01; m_awqos[m] = 4'd0;
            if (!(m_wvalid[m] && !hs_w[m]))
               m_wvalid[m] = (w_j[m] < NB) && ($urandom_range(0, 3) != 0);
            m_wdata[m] = f_data(m, w_j[m], w_b[m]);
            m_wstrb[m] = f_strb(m, w_j[m], w_b[m]);
            m_wlast[m] = (w_b[m] == int'(f_len(m, w_j[m])));
         end
         s_awready = ($urandom_range(0, 2) != 0);
         s_wready  = ($urandom_range(0, 3) != 0);
         done = (w_j[0] == NB) && (w_j[1] == NB) && (ordq.size() == 0);
      end
      check("rnd_all_done", {done, aw_seen[0] == NB, aw_seen[1] == NB}, 3'b111);
   endtask

   initial begin
      idle_inputs();
      t_reset_and_rr();
      t_hold_stable();
      t_ost_and_reset();
      t_w_order();
      t_qos();
      t_b_table();
      t_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/svk_axi_wr_arb.md
SVK_AXI_WR_ARB -- requirements
Module: svk_axi_wr_arb

Interface
REQ-001 Parameter ID_W, default 4, master-side AXI ID width; slave-side ID width SHALL be ID_W+1.
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter DATA_W, default 64, data width; strobe width DATA_W/8.
REQ-004 Parameter LEN_W, default 8, burst length width.
REQ-005 Parameter OST, default 4, depth of the write-order FIFO (power of two, 2..16).
REQ-006 aclk  in  1  clock; all logic on its rising edge.
REQ-007 aresetn  in  1  reset, synchronous and active-low.
REQ-008 mN_awvalid/awready/awid/awaddr/awlen/awsize/awburst/awqos  in/out/in...  1/1/ID_W/ADDR_W/LEN_W/3/2/4  AW channel of master N (N=0,1).
REQ-009 mN_wvalid/wready/wdata/wstrb/wlast  in/out/in/in/in  1/1/DATA_W/DATA_W/8/1  W channel of master N.
REQ-010 mN_bvalid/bready/bid/bresp  out/in/out/out  1/1/ID_W/2  B channel of master N.
REQ-011 s_aw*, s_w*, s_b*  mirrored directions, same widths except s_awid/s_bid at ID_W+1  single downstream slave port.

Function
REQ-012 AW arbiter states: AW_IDLE (no grant), AW_HOLD (s_awvalid=1, waiting for s_awready).
REQ-013 In AW_IDLE, with at least one mN_awvalid and FIFO not full, arbiter SHALL register a grant and enter AW_HOLD next cycle.
REQ-014 Arbitration without QoS: round-robin; after master k is granted, master 1-k has priority next time; after reset master 0 has priority.
REQ-015 In AW_HOLD, s_aw* SHALL be driven from registered copies and remain stable until s_awvalid&s_awready.
REQ-016 s_awid SHALL equal {N, mN_awid}; mN_awready SHALL pulse for exactly the one cycle the payload is captured (AW_IDLE->AW_HOLD).
REQ-017 On s_aw handshake, index N SHALL be pushed into the write-order FIFO and the arbiter SHALL return to AW_IDLE; back-to-back grants give one AW per two cycles minimum.
REQ-018 FIFO full: no new grant; all mN_awready=0 until a pop.
REQ-019 W router states: W_IDLE (FIFO empty), W_BURST (forwarding W beats of FIFO-head master).
REQ-020 In W_BURST, s_w* = head master's W signals combinationally; head mN_wready = s_wready; other master's wready = 0.
REQ-021 A W handshake with wlast=1 SHALL pop the FIFO; next head forwarded the following cycle, or W_IDLE if empty.
REQ-022 Simultaneous push and pop SHALL keep occupancy unchanged; push to a FIFO that becomes non-full in the same cycle is not permitted (full check uses registered count).
REQ-023 W beats from a master whose AW is not yet at FIFO head SHALL be stalled (wready=0); W before AW is not forwarded.
REQ-024 B routing: mN_bvalid = s_bvalid & (s_bid[ID_W]==N); mN_bid = s_bid[ID_W-1:0]; mN_bresp = s_bresp; s_bready = selected mN_bready; purely combinational.

Reset
REQ-025 While aresetn=0 at a clock edge: states to AW_IDLE/W_IDLE, FIFO emptied, round-robin pointer to master 0, s_awvalid=0, all mN_awready=0, registered s_aw* payload to 0.
REQ-026 Reset mid-burst SHALL abandon in-flight AW/W without completing them; s_wvalid=0 from the first cycle after reset.

Configuration
REQ-027 Macro SVK_AXI_WR_ARB_QOS_EN defined: in AW_IDLE the valid master with strictly higher awqos wins; ties fall back to round-robin (REQ-014).
REQ-028 Macro undefined: awqos ports are still present and forwarded to s_awqos but ignored for arbitration.

Verification
REQ-029 Both masters assert awvalid with awlen=0 from reset -> grants m0, m1, m0, m1; s_awid MSB 0,1,0,1.
REQ-030 m0 AW len=3 then m1 AW len=1, m1 presents W first -> m1 wready=0 until m0's 4th beat (wlast) handshakes; then 2 m1 beats forwarded.
REQ-031 s_awready held 0 for 5 cycles in AW_HOLD -> s_aw* payload stable all 5 cycles, no new mN_awready pulse.
REQ-032 OST=4, s_wready=0, 5 single-beat AWs issued -> 4 accepted, 5th stalled until first wlast handshake.
REQ-033 s_bvalid with s_bid={1,4'h3}, bresp=2 -> m1_bvalid=1, m1_bid=3, m1_bresp=2, m0_bvalid=0; s_bready follows m1_bready.
REQ-034 QOS_EN: m0 awqos=2, m1 awqos=9, both valid -> m1 granted; equal qos -> round-robin; aresetn=0 during burst -> all outputs at reset values next cycle.
